fpu_operand_sequencer: RTL and testbench

- Upstream feeder for the FPU adder/subtractor. It sits directly in front of the FPU's Op_A_in/Op_B_in operand inputs.
- Accepts IEEE-754 single-precision operand pairs over a valid/ready interface and buffers them in a small FIFO.
- Presents each pair to the FPU as stable operands, held for a fixed number of clock cycles, then advances to the next pair.
- Replaces hand-timed operand driving with a deterministic, back-pressured issue stream.

---
 rtl/fpu_pkg.sv | 17 +
 rtl/sync_fifo.sv | 61 ++++++
 rtl/fpu_operand_sequencer.sv | 114 +++++++++++
 tb/tb_fpu_operand_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared types for the FPU operand sequencer: operand width, the operand-pair
// record carried through the FIFO, and the issue FSM states.
package fpu_pkg;

  localparam int FP_WIDTH = 32;

  typedef struct packed {
    logic [FP_WIDTH-1:0] op_a;
    logic [FP_WIDTH-1:0] op_b;
  } fp_pair_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } seq_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage and show-ahead read: rdata is
// always the entry at the read pointer. clear drops all contents synchronously.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset so it can map onto plain memory cells.
  always_ff @(posedge clk) begin
    if (push_ok && !clear) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fpu_operand_sequencer.sv
// Buffers operand pairs and presents each one to the FPU adder for HOLD_CYCLES
// cycles. Optional statistics counters are enabled by defining FPU_SEQ_STATS_EN.
module fpu_operand_sequencer
  import fpu_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                         clock_100Khz,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [FP_WIDTH-1:0]          in_op_a,
  input  logic [FP_WIDTH-1:0]          in_op_b,
  input  logic                         flush,
  output logic [FP_WIDTH-1:0]          Op_A_out,
  output logic [FP_WIDTH-1:0]          Op_B_out,
  output logic                         issue,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
`ifdef FPU_SEQ_STATS_EN
  ,
  output logic [15:0]                  issued_count,
  output logic [7:0]                   flushed_count
`endif
);

  localparam int HW = $clog2(HOLD_CYCLES+1);
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_CYCLES-1);

  seq_state_e    state;
  logic [HW-1:0] hold_cnt;
  logic          ready_en;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  fp_pair_t      wdata;
  fp_pair_t      head;

  // ready_en keeps in_ready low until the first edge after reset release.
  assign in_ready = ready_en && !full && !flush;
  assign push     = in_valid && in_ready;
  assign pop      = !flush && !empty && ((state == IDLE) || (hold_cnt == '0));
  assign busy     = (state == HOLD);
  assign wdata    = '{op_a: in_op_a, op_b: in_op_b};

  sync_fifo #(
    .WIDTH ($bits(fp_pair_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clock_100Khz),
    .rst_n (reset),
    .clear (flush),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_ff @(posedge clock_100Khz or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
      issue    <= 1'b0;
      ready_en <= 1'b0;
      Op_A_out <= '0;
      Op_B_out <= '0;
    end else begin
      ready_en <= 1'b1;
      issue    <= pop;
      if (flush) begin
        state    <= IDLE;
        hold_cnt <= '0;
      end else if (pop) begin
        state    <= HOLD;
        hold_cnt <= HOLD_RELOAD;
        Op_A_out <= head.op_a;
        Op_B_out <= head.op_b;
      end else if (state == HOLD) begin
        if (hold_cnt != '0) begin
          hold_cnt <= hold_cnt - HW'(1);
        end else begin
          state <= IDLE;
        end
      end
    end
  end

`ifdef FPU_SEQ_STATS_EN
  logic [8:0] flush_sum;

  assign flush_sum = {1'b0, flushed_count} + 9'(fifo_count);

  // Both counters saturate; flush does not clear them.
  always_ff @(posedge clock_100Khz or negedge reset) begin
    if (!reset) begin
      issued_count  <= '0;
      flushed_count <= '0;
    end else begin
      if (pop && (issued_count != 16'hFFFF)) begin
        issued_count <= issued_count + 16'd1;
      end
      if (flush) begin
        flushed_count <= flush_sum[8] ? 8'hFF : flush_sum[7:0];
      end
    end
  end
`endif

endmodule

// File: tb/tb_fpu_operand_sequencer.sv
// Bench for fpu_operand_sequencer: three instances (hold 2, hold 1, hold 8)
// sharing clock, reset, operands and flush; main instance checked by scoreboard.
module tb_fpu_operand_sequencer;
  import fpu_pkg::*;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        m_vld, f_vld, b_vld;
  logic        m_rdy, f_rdy, b_rdy;
  logic [31:0] m_a, m_b, f_a, f_b, b_a, b_b;
  logic        m_issue, f_issue, b_issue;
  logic        m_busy, f_busy, b_busy;
  logic [2:0]  m_count, f_count, b_count;
`ifdef FPU_SEQ_STATS_EN
  logic [15:0] m_issued, f_issued, b_issued;
  logic [7:0]  m_flushed, f_flushed, b_flushed;
`endif

  int tests = 0;
  int fails = 0;

  vec_t vecs[4];
  vec_t bp_vecs[6];

  logic [63:0] sb[$];
  logic [63:0] b_seen[$];
  logic [63:0] cur;
  int          held;
  bit          tracking;

  always #5 clk = ~clk;

  fpu_operand_sequencer #(.DEPTH(4), .HOLD_CYCLES(2)) u_main (
    .clock_100Khz (clk), .reset (reset), .in_valid (m_vld), .in_ready (m_rdy),
    .in_op_a (op_a), .in_op_b (op_b), .flush (flush),
    .Op_A_out (m_a), .Op_B_out (m_b), .issue (m_issue), .busy (m_busy),
    .fifo_count (m_count)
`ifdef FPU_SEQ_STATS_EN
    , .issued_count (m_issued), .flushed_count (m_flushed)
`endif
  );

  fpu_operand_sequencer #(.DEPTH(4), .HOLD_CYCLES(1)) u_fast (
    .clock_100Khz (clk), .reset (reset), .in_valid (f_vld), .in_ready (f_rdy),
    .in_op_a (op_a), .in_op_b (op_b), .flush (flush),
    .Op_A_out (f_a), .Op_B_out (f_b), .issue (f_issue), .busy (f_busy),
    .fifo_count (f_count)
`ifdef FPU_SEQ_STATS_EN
    , .issued_count (f_issued), .flushed_count (f_flushed)
`endif
  );

  fpu_operand_sequencer #(.DEPTH(4), .HOLD_CYCLES(8)) u_bp (
    .clock_100Khz (clk), .reset (reset), .in_valid (b_vld), .in_ready (b_rdy),
    .in_op_a (op_a), .in_op_b (op_b), .flush (flush),
    .Op_A_out (b_a), .Op_B_out (b_b), .issue (b_issue), .busy (b_busy),
    .fifo_count (b_count)
`ifdef FPU_SEQ_STATS_EN
    , .issued_count (b_issued), .flushed_count (b_flushed)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic rdy_of(input int w);
    return (w == 0) ? m_rdy : ((w == 1) ? f_rdy : b_rdy);
  endfunction

  // Holds in_valid until the handshake completes; called at posedge+1.
  task automatic push(input int which, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] ea, input logic [31:0] eb);
    op_a = a;
    op_b = b;
    case (which)
      0:       m_vld = 1'b1;
      1:       f_vld = 1'b1;
      default: b_vld = 1'b1;
    endcase
    for (int t = 0; t < 100 && !rdy_of(which); t++) begin
      @(posedge clk);
      #1;
    end
    chk("push_ready", rdy_of(which), 1'b1);
    if (which == 0) sb.push_back({ea, eb});
    @(posedge clk);
    #1;
    m_vld = 1'b0;
    f_vld = 1'b0;
    b_vld = 1'b0;
  endtask

  // Scoreboard and hold-window monitor for the main instance.
  always @(negedge clk) begin
    if (!reset) begin
      sb.delete();
      tracking = 1'b0;
    end else begin
      if (m_issue) begin
        if (tracking) chk("hold_len", held, 2);
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_issue: got issue of %0h, expected no issue", {m_a, m_b});
        end else begin
          cur = sb.pop_front();
          chk("issue_ops", {m_a, m_b}, cur);
        end
        held = 1;
        tracking = 1'b1;
      end else if (m_busy) begin
        held++;
        chk("hold_stable", {m_a, m_b}, cur);
      end else begin
        if (tracking) chk("hold_len", held, 2);
        tracking = 1'b0;
      end
      if (flush) begin
        tracking = 1'b0;
        sb.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) b_seen.delete();
    else if (b_issue) b_seen.push_back({b_a, b_b});
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int size0;
    reset = 1'b0; flush = 1'b0; op_a = '0; op_b = '0;
    m_vld = 1'b0; f_vld = 1'b0; b_vld = 1'b0;

    vecs[0] = '{32'h40B80000, 32'h3FA00000, 32'h40B80000, 32'h3FA00000};
    vecs[1] = '{32'h40400000, 32'h00000000, 32'h40400000, 32'h00000000};
    vecs[2] = '{32'hC0000000, 32'h00000000, 32'hC0000000, 32'h00000000};
    vecs[3] = '{32'h41000000, 32'hC1000000, 32'h41000000, 32'hC1000000};
    for (int i = 0; i < 4; i++) bp_vecs[i] = vecs[i];
    bp_vecs[4] = '{32'h3F800000, 32'h3F000000, 32'h3F800000, 32'h3F000000};
    bp_vecs[5] = '{32'hBFC00000, 32'h40800000, 32'hBFC00000, 32'h40800000};

    // Reset state
    #1;
    chk("rst_op", {m_a, m_b}, 64'h0);
    chk("rst_issue", m_issue, 1'b0);
    chk("rst_busy", m_busy, 1'b0);
    chk("rst_count", m_count, 3'd0);
    chk("rst_ready", m_rdy, 1'b0);
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    #1 chk("ready_before_edge", m_rdy, 1'b0);
    @(posedge clk); #1;
    chk("ready_after_edge", m_rdy, 1'b1);

    // Single pair, exact latency and hold window
    push(0, 32'h3FC00000, 32'h40100000, 32'h3FC00000, 32'h40100000);
    chk("single_count", m_count, 3'd1);
    chk("single_no_issue_yet", m_issue, 1'b0);
    @(posedge clk); #1;
    chk("single_issue", m_issue, 1'b1);
    chk("single_busy1", m_busy, 1'b1);
    chk("single_ops", {m_a, m_b}, {32'h3FC00000, 32'h40100000});
    chk("single_popped", m_count, 3'd0);
    @(posedge clk); #1;
    chk("single_issue_pulse", m_issue, 1'b0);
    chk("single_busy2", m_busy, 1'b1);
    @(posedge clk); #1;
    chk("single_idle", m_busy, 1'b0);
    chk("single_retained", {m_a, m_b}, {32'h3FC00000, 32'h40100000});
    repeat (2) @(posedge clk); #1;

    // Back-to-back stream from the table
    fork
      begin
        for (int i = 0; i < 4; i++) push(0, vecs[i].a, vecs[i].b, vecs[i].exp_a, vecs[i].exp_b);
      end
      begin
        int t, run, iss;
        t = 0; run = 0; iss = 0;
        while (!m_issue && t < 20) begin @(negedge clk); t++; end
        chk("stream_start", m_issue, 1'b1);
        while (m_busy && run < 40) begin
          if (m_issue) iss++;
          run++;
          @(negedge clk);
        end
        chk("stream_busy_run", run, 8);
        chk("stream_issues", iss, 4);
      end
    join
    repeat (3) @(posedge clk); #1;

    // Reset asserted mid-hold, then recovery
    push(0, 32'h3F800000, 32'h40000000, 32'h3F800000, 32'h40000000);
    push(0, 32'h40A00000, 32'h40C00000, 32'h40A00000, 32'h40C00000);
    chk("pre_reset_busy", m_busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_op", {m_a, m_b}, 64'h0);
    chk("midrst_busy", m_busy, 1'b0);
    chk("midrst_issue", m_issue, 1'b0);
    chk("midrst_count", m_count, 3'd0);
    chk("midrst_ready", m_rdy, 1'b0);
    sb.delete();
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    #1 chk("rerst_ready_before_edge", m_rdy, 1'b0);
    @(posedge clk); #1;
    chk("rerst_ready", m_rdy, 1'b1);
    push(0, 32'h41200000, 32'hC1200000, 32'h41200000, 32'hC1200000);
    for (int t = 0; t < 20 && sb.size() != 0; t++) @(negedge clk);
    chk("rerst_drain", sb.size(), 0);
    chk("rerst_ops", {m_a, m_b}, {32'h41200000, 32'hC1200000});
`ifdef FPU_SEQ_STATS_EN
    chk("main_issued", m_issued, 16'd1);
`endif
    @(posedge clk); #1;

    // HOLD_CYCLES=1 drain: one pair per cycle
    fork
      begin
        for (int i = 0; i < 4; i++) push(1, vecs[i].a, vecs[i].b, vecs[i].exp_a, vecs[i].exp_b);
      end
      begin
        int t;
        t = 0;
        while (!f_issue && t < 20) begin @(negedge clk); t++; end
        for (int i = 0; i < 4; i++) begin
          chk("fast_issue", f_issue, 1'b1);
          chk("fast_ops", {f_a, f_b}, {vecs[i].exp_a, vecs[i].exp_b});
          @(negedge clk);
        end
        chk("fast_end_issue", f_issue, 1'b0);
        chk("fast_end_busy", f_busy, 1'b0);
      end
    join
`ifdef FPU_SEQ_STATS_EN
    chk("fast_issued", f_issued, 16'd4);
`endif
    @(posedge clk); #1;

    // Back-pressure behind a long hold
    for (int i = 0; i < 5; i++) push(2, bp_vecs[i].a, bp_vecs[i].b, bp_vecs[i].exp_a, bp_vecs[i].exp_b);
    chk("bp_full_ready", b_rdy, 1'b0);
    chk("bp_full_count", b_count, 3'd4);
    push(2, bp_vecs[5].a, bp_vecs[5].b, bp_vecs[5].exp_a, bp_vecs[5].exp_b);
    chk("bp_accept_after_pop", b_seen.size(), 2);
    chk("bp_refill_count", b_count, 3'd4);
    for (int t = 0; t < 100 && b_seen.size() < 6; t++) @(negedge clk);
    chk("bp_total", b_seen.size(), 6);
    for (int i = 0; i < 6 && i < b_seen.size(); i++)
      chk("bp_order", b_seen[i], {bp_vecs[i].exp_a, bp_vecs[i].exp_b});
    for (int t = 0; t < 40 && b_busy; t++) @(negedge clk);
    @(posedge clk); #1;

    // Flush mid-hold with 3 pairs queued
    size0 = b_seen.size();
    for (int i = 0; i < 4; i++) push(2, vecs[i].a, vecs[i].b, vecs[i].exp_a, vecs[i].exp_b);
    chk("preflush_count", b_count, 3'd3);
    chk("preflush_busy", b_busy, 1'b1);
    flush = 1'b1;
    #1;
    chk("flush_ready_bp", b_rdy, 1'b0);
    chk("flush_ready_main", m_rdy, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_count", b_count, 3'd0);
    chk("flush_busy", b_busy, 1'b0);
    chk("flush_issue", b_issue, 1'b0);
    chk("flush_ops_kept", {b_a, b_b}, {vecs[0].exp_a, vecs[0].exp_b});
    repeat (12) @(negedge clk);
    chk("flush_no_issue", b_seen.size(), size0 + 1);
    chk("flush_still_idle", b_busy, 1'b0);
`ifdef FPU_SEQ_STATS_EN
    chk("bp_flushed", b_flushed, 8'd3);
    chk("bp_issued", b_issued, 16'd7);
    chk("main_flushed", m_flushed, 8'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
